ex_muldiv: RTL and testbench

- Iterative RV32M multiply/divide unit; sits beside the execute stage and receives R_M-type instructions with funct7 = 7'b000_0001.
- Holds the pipeline through hold_flag (busy_o) while it iterates.
- Returns one write-back (rd_addr_o / rd_data_o / rd_wen_o) per accepted operation.
- Operand width is parametrised; radix-2 shift-add multiply, restoring divide.

---
 rtl/ex_muldiv.sv | 170 +++++++++++++++++
 tb/tb_ex_muldiv.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with a single-cycle fast path for divide-by-zero and signed overflow.
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            ready_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_wen_o
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_funct3;
    logic              r_s1;
    logic              r_s2;
    logic [XLEN-1:0]   r_op;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_rd_data;
    logic [4:0]        r_rd_addr;
    logic              r_ready;

    logic              w_start;
    logic              w_sgn1;
    logic              w_sgn2;
    logic              w_n1;
    logic              w_n2;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic              w_div0;
    logic              w_ovf;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_res;
    logic              w_last;
    logic [XLEN:0]     w_msum;
    logic [XLEN:0]     w_rsh;
    logic              w_ge;
    logic [XLEN-1:0]   w_sub;
    logic [2*XLEN-1:0] w_mul_nx;
    logic [2*XLEN-1:0] w_div_nx;
    logic [2*XLEN-1:0] w_acc_nx;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_res;

    assign w_start    = start_i & ~flush_i;
    assign w_sgn1     = (funct3_i == 3'd1) | (funct3_i == 3'd2) | (funct3_i == 3'd4) | (funct3_i == 3'd6);
    assign w_sgn2     = (funct3_i == 3'd1) | (funct3_i == 3'd4) | (funct3_i == 3'd6);
    assign w_n1       = w_sgn1 & op1_i[XLEN-1];
    assign w_n2       = w_sgn2 & op2_i[XLEN-1];
    assign w_abs1     = w_n1 ? -op1_i : op1_i;
    assign w_abs2     = w_n2 ? -op2_i : op2_i;
    assign w_div0     = (op2_i == '0);
    assign w_ovf      = ~funct3_i[0] & (op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (op2_i == '1);
    assign w_fast     = funct3_i[2] & (w_div0 | w_ovf);
    assign w_fast_res = w_div0 ? (funct3_i[1] ? op1_i : '1) : (funct3_i[1] ? '0 : op1_i);

    assign w_last   = (r_cnt == CNT_W'(XLEN - 1));
    assign w_msum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_op} : '0);
    assign w_mul_nx = {w_msum, r_acc[XLEN-1:1]};
    // Remainder after a successful subtract is below the divisor, so XLEN bits suffice.
    assign w_rsh    = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_ge     = (w_rsh >= {1'b0, r_op});
    assign w_sub    = w_rsh[XLEN-1:0] - r_op;
    assign w_div_nx = w_ge ? {w_sub, r_acc[XLEN-2:0], 1'b1}
                           : {w_rsh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    assign w_acc_nx = r_funct3[2] ? w_div_nx : w_mul_nx;
    assign w_prod   = (r_s1 ^ r_s2) ? -w_acc_nx : w_acc_nx;
    assign w_quo    = w_acc_nx[XLEN-1:0];
    assign w_rem    = w_acc_nx[2*XLEN-1:XLEN];

    always_comb begin
        w_res = '0;
        case (r_funct3)
            3'd0:                w_res = w_prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    w_res = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:          w_res = (r_s1 ^ r_s2) ? -w_quo : w_quo;
            default:             w_res = r_s1 ? -w_rem : w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o = w_start;
                if (w_start) w_next = w_fast ? S_DONE : S_CALC;
            end
            S_CALC: begin
                busy_o = ~flush_i;
                if (flush_i)     w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_funct3  <= '0;
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_op      <= '0;
            r_acc     <= '0;
            r_rd_data <= '0;
            r_rd_addr <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_funct3  <= funct3_i;
                    r_rd_addr <= rd_addr_i;
                    r_s1      <= w_n1;
                    r_s2      <= w_n2;
                    r_cnt     <= '0;
                    // Divide keeps the dividend in the accumulator; multiply keeps the multiplier there.
                    if (funct3_i[2]) begin
                        r_op  <= w_abs2;
                        r_acc <= {{XLEN{1'b0}}, w_abs1};
                    end else begin
                        r_op  <= w_abs1;
                        r_acc <= {{XLEN{1'b0}}, w_abs2};
                    end
                    if (w_fast) begin
                        r_rd_data <= w_fast_res;
                        r_ready   <= 1'b1;
                    end
                end
                S_CALC: if (!flush_i) begin
                    r_acc <= w_acc_nx;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_rd_data <= w_res;
                        r_ready   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_o   = r_ready;
    assign rd_wen_o  = r_ready;
    assign rd_data_o = r_rd_data;
    assign rd_addr_o = r_rd_addr;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed test-plan operations with literal results, then random
// traffic, all compared cycle by cycle against an arithmetic model of the unit.
module tb_ex_muldiv;

    localparam int          XLEN = 32;
    localparam logic [31:0] MIN  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] op1_i = '0;
    logic [31:0] op2_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic        ready_o;
    logic [31:0] rd_data_o;
    logic [4:0]  rd_addr_o;
    logic        rd_wen_o;

    logic        lit_arm = 1'b0;
    logic [31:0] lit_data = '0;
    int          lit_lat = 0;

    int n_chk = 0;
    int n_pass = 0;

    ex_muldiv #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .funct3_i(funct3_i),
        .op1_i(op1_i), .op2_i(op2_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
        .busy_o(busy_o), .ready_o(ready_o), .rd_data_o(rd_data_o),
        .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, p;
        logic [63:0] pv;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'd0: begin pv = {32'b0, a} * {32'b0, b}; return pv[31:0]; end
            3'd1: begin p = sa * sb; pv = p; return pv[63:32]; end
            3'd2: begin p = sa * ub; pv = p; return pv[63:32]; end
            3'd3: begin pv = {32'b0, a} * {32'b0, b}; return pv[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f < 3'd4) return 1'b0;
        if (b == 0) return 1'b1;
        return (f == 3'd4 || f == 3'd6) && a == MIN && b == 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Model: an accepted op finishes a fixed number of cycles later unless flushed or reset.
    int          cyc = 0;
    bit          m_pend = 1'b0;
    int          m_rdy = 0;
    int          m_start = 0;
    logic [31:0] m_data = '0;
    logic [31:0] m_last = '0;
    logic [4:0]  m_addr = '0;
    bit          m_has_lit = 1'b0;
    logic [31:0] m_lit_data = '0;
    int          m_lit_lat = 0;

    always @(negedge clk) begin
        bit in_calc, in_done, idle, exp_busy;
        cyc++;
        if (!rst) begin
            m_pend = 1'b0;
            m_has_lit = 1'b0;
            m_last = '0;
            chk("rst_busy", 32'(busy_o), 32'd0);
            chk("rst_ready", 32'(ready_o), 32'd0);
            chk("rst_wen", 32'(rd_wen_o), 32'd0);
            chk("rst_data", rd_data_o, 32'd0);
            chk("rst_addr", 32'(rd_addr_o), 32'd0);
        end else begin
            in_calc  = m_pend && cyc < m_rdy;
            in_done  = m_pend && cyc == m_rdy;
            idle     = !m_pend;
            exp_busy = (idle && start_i && !flush_i) || (in_calc && !flush_i);
            chk("busy", 32'(busy_o), 32'(exp_busy));
            chk("ready", 32'(ready_o), 32'(in_done));
            chk("wen", 32'(rd_wen_o), 32'(in_done));
            if (m_has_lit && ready_o) begin
                chk("lit_latency", 32'(cyc - m_start), 32'(m_lit_lat));
                chk("lit_data", rd_data_o, m_lit_data);
                m_has_lit = 1'b0;
            end
            if (in_done) begin
                chk("data", rd_data_o, m_data);
                chk("addr", 32'(rd_addr_o), 32'(m_addr));
                m_last = m_data;
                m_pend = 1'b0;
                m_has_lit = 1'b0;
            end else begin
                chk("hold_data", rd_data_o, m_last);
                if (in_calc && flush_i) begin
                    m_pend = 1'b0;
                    m_has_lit = 1'b0;
                end
            end
            if (idle && start_i && !flush_i) begin
                m_pend     = 1'b1;
                m_start    = cyc;
                m_rdy      = cyc + (is_fast(funct3_i, op1_i, op2_i) ? 1 : XLEN + 1);
                m_data     = ref_res(funct3_i, op1_i, op2_i);
                m_addr     = rd_addr_i;
                m_has_lit  = lit_arm;
                m_lit_data = lit_data;
                m_lit_lat  = lit_lat;
            end
        end
    end

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] expd, input int lat);
        @(posedge clk); #1;
        start_i = 1'b1; funct3_i = f; op1_i = a; op2_i = b; rd_addr_i = rd;
        lit_arm = 1'b1; lit_data = expd; lit_lat = lat;
        @(posedge clk); #1;
        start_i = 1'b0; lit_arm = 1'b0;
        repeat (lat) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33);
        do_op(3'd1, MIN, MIN, 5'd6, 32'h4000_0000, 33);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 33);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, 33);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 33);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 33);
        do_op(3'd7, 32'd100, 32'd7, 5'd11, 32'd2, 33);
        do_op(3'd5, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 1);
        do_op(3'd6, 32'd5, 32'd0, 5'd13, 32'd5, 1);
        do_op(3'd4, MIN, 32'hFFFF_FFFF, 5'd0, MIN, 1);
        do_op(3'd6, MIN, 32'hFFFF_FFFF, 5'd14, 32'd0, 1);

        // Flush a MUL in its cycle 10, restart in cycle 12.
        @(posedge clk); #1;
        start_i = 1'b1; funct3_i = 3'd0; op1_i = 32'd123; op2_i = 32'd456; rd_addr_i = 5'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        do_op(3'd5, 32'd9, 32'd3, 5'd16, 32'd3, 33);

        // Reset in cycle 5 of a DIV, then 40 quiet cycles and a normal op.
        @(posedge clk); #1;
        start_i = 1'b1; funct3_i = 3'd4; op1_i = 32'd1000; op2_i = 32'd7; rd_addr_i = 5'd4;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (40) @(posedge clk);
        do_op(3'd5, 32'd1000, 32'd7, 5'd15, 32'd142, 33);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start_i   = ($urandom_range(0, 3) != 0);
            flush_i   = ($urandom_range(0, 79) == 0);
            funct3_i  = 3'($urandom_range(0, 7));
            rd_addr_i = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 5))
                0: begin op1_i = $urandom; op2_i = '0; end
                1: begin op1_i = MIN; op2_i = 32'hFFFF_FFFF; end
                2: begin
                    op1_i = $urandom_range(0, 40);
                    op2_i = $urandom_range(1, 9);
                    if ($urandom_range(0, 1) == 1) op1_i = -op1_i;
                    if ($urandom_range(0, 1) == 1) op2_i = -op2_i;
                end
                default: begin op1_i = $urandom; op2_i = $urandom; end
            endcase
        end
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
